// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = $clog2(DIV_ITER);

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so a restored rem_sh fits back into WIDTH bits.
    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider: quotient to LO, remainder to HI.
// Handshake: start is accepted only in IDLE (busy low); busy stays high until the
// DONE cycle, in which done pulses once and results are valid; cancel aborts to IDLE.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div0_q, div0_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (dq_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvsr_d      = dvsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div0_d      = div0_q;

        // An abort must not let FIX commit a half-finished result.
        if (cancel && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !cancel) begin
                        q_neg_d = Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        r_neg_d = Sign & in1[WIDTH-1];
                        dq_d    = (Sign && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
                        dvsr_d  = (Sign && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(DIV_ITER - 1);
                        if (in2 == '0) begin
                            quotient_d  = WIDTH'(DIV0_QUOT);
                            remainder_d = in1;
                            div0_d      = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = step_rem;
                    dq_d  = step_quo;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_FIX: begin
                    quotient_d  = q_neg_q ? (~dq_q + 1'b1) : dq_q;
                    remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
                    div0_d      = 1'b0;
                    state_d     = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvsr_q      <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div0_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dvsr_q      <= dvsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div0_q      <= div0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus start/cancel/reset sequences.
module tb_div_unit;

  localparam int K_NONE   = 0;
  localparam int K_START  = 1;
  localparam int K_CANCEL = 2;
  localparam int K_RESET  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic        Sign;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div0;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_d0;
    int          done_cyc;
  } vec_t;

  vec_t vecs[13];

  div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .Sign      (Sign),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts one divide at the current negedge (cycle 0) and follows it for 40 cycles.
  // inj_kind applies start/cancel/reset during cycle inj_cyc.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int inj_cyc, input int inj_kind,
                        input int done_cyc, input logic [31:0] eq, input logic [31:0] er,
                        input logic ed0);
    logic aborted;
    logic exp_busy;
    logic exp_done;
    start = 1'b1;
    Sign  = sgn;
    in1   = a;
    in2   = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        Sign  = 1'($urandom_range(0, 1));
        in1   = $urandom;
        in2   = $urandom;
      end
      if (cyc == inj_cyc + 1) begin
        start  = 1'b0;
        cancel = 1'b0;
        reset  = 1'b1;
      end
      aborted  = (inj_kind == K_CANCEL || inj_kind == K_RESET) && cyc > inj_cyc;
      exp_busy = !aborted && cyc <= done_cyc;
      exp_done = !aborted && cyc == done_cyc;
      check($sformatf("%s busy c%0d", tag, cyc), 32'(busy), 32'(exp_busy));
      check($sformatf("%s done c%0d", tag, cyc), 32'(done), 32'(exp_done));
      if (exp_done || (aborted && cyc == inj_cyc + 1)) begin
        check($sformatf("%s quotient", tag), quotient, eq);
        check($sformatf("%s remainder", tag), remainder, er);
        check($sformatf("%s div0", tag), 32'(div0), 32'(ed0));
      end
      if (cyc == inj_cyc) begin
        case (inj_kind)
          K_START: begin
            start = 1'b1;
            Sign  = 1'b0;
            in1   = 32'd50;
            in2   = 32'd5;
          end
          K_CANCEL: cancel = 1'b1;
          K_RESET:  reset = 1'b0;
          default:  ;
        endcase
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 34};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0, 34};
    vecs[5]  = '{1'b0, 32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1, 1};
    vecs[6]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 34};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFA,  32'd3,          32'hFFFF_FFFE,  32'd0,          1'b0, 34};
    vecs[10] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 34};
    vecs[11] = '{1'b0, 32'h1234_5678,  32'h0000_1000,  32'h0001_2345,  32'h0000_0678,  1'b0, 34};
    vecs[12] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1};

    reset  = 1'b0;
    start  = 1'b0;
    cancel = 1'b0;
    Sign   = 1'b0;
    in1    = '0;
    in2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div0", 32'(div0), 32'd0);

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, -5, K_NONE,
             vecs[i].done_cyc, vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_d0);
    end

    // start while busy is ignored
    run_op("ign_start", 1'b0, 32'd100, 32'd7, 10, K_START, 34, 32'd14, 32'd2, 1'b0);
    // cancel mid-divide keeps the previous results
    run_op("cancel", 1'b0, 32'd1000, 32'd3, 10, K_CANCEL, 34, 32'd14, 32'd2, 1'b0);

    // cancel beats a simultaneous start in IDLE (divide-by-zero would finish in one cycle)
    start  = 1'b1;
    cancel = 1'b1;
    Sign   = 1'b0;
    in1    = 32'd9;
    in2    = 32'd0;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    check("cancel_vs_start busy", 32'(busy), 32'd0);
    check("cancel_vs_start done", 32'(done), 32'd0);
    check("cancel_vs_start div0", 32'(div0), 32'd0);
    check("cancel_vs_start quotient", quotient, 32'd14);

    // reset mid-divide clears everything
    run_op("reset_mid", 1'b0, 32'd100, 32'd7, 20, K_RESET, 34, 32'd0, 32'd0, 1'b0);
    run_op("after_reset", 1'b1, 32'd7, 32'hFFFF_FFFE, -5, K_NONE, 34,
           32'hFFFF_FFFD, 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the MIPS datapath, complementing the single-cycle ALU, which multiplies but has no divide. It accepts a dividend/divisor pair with a `Sign` mode bit on a start pulse and iterates one quotient bit per cycle (restoring division on magnitudes). It returns quotient (LO) and remainder (HI) with a one-cycle `done` pulse. It sits beside the ALU in EX; the control unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is verified.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `cancel`  in  1  abort in-flight divide (exception flush)
- `Sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with `start`
- `in1`  in  32  dividend, captured with `start`
- `in2`  in  32  divisor, captured with `start`
- `busy`  out  1  high from the cycle after an accepted start through the DONE cycle
- `done`  out  1  one-cycle pulse; `quotient`/`remainder`/`div0` valid that cycle
- `quotient`  out  32  LO result, held until next accepted start
- `remainder`  out  32  HI result, held until next accepted start
- `div0`  out  1  last accepted divide had `in2 == 0`; held with results

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on `start`, latch `Sign`, the magnitudes |in1| and |in2| (magnitudes only when `Sign`=1), and the result-sign bits: quotient negative = in1[31]^in2[31], remainder negative = in1[31].
  - If `in2 == 0`, go to DONE with quotient = 32'hFFFFFFFF, remainder = in1, div0 = 1.
  - Otherwise go to CALC and load counter = 31.
- CALC: one restoring step per cycle.
  - Compute {rem, dq} shifted left by 1, then trial = rem − divisor (33-bit).
  - If trial is non-negative, rem = trial and the new quotient LSB = 1; else the LSB = 0.
  - After 32 steps (counter reaching 0), go to FIX.
- FIX: conditionally two's-complement negate the quotient and remainder per the latched sign bits; go to DONE.
- DONE: `done` = 1 for exactly one cycle; go to IDLE.
- Magnitude arithmetic is 32-bit unsigned, so |0x80000000| = 0x80000000 is correct. Signed 0x80000000 / −1 therefore yields quotient 0x80000000 and remainder 0 with no special case.
- Remainder sign always equals the dividend sign; a zero remainder is never negated into a nonzero value.
- `start` outside IDLE is ignored (no queueing).
- `cancel` in CALC, FIX or DONE: next state is IDLE, with `busy` = 0 and `done` = 0. Result registers keep their previous values. `cancel` in IDLE has no effect, and it beats a simultaneous `start`.
- Simultaneous `start` and `done`: not possible, since `start` is only accepted in IDLE.
- Reset (`reset` low at a clock edge): state IDLE; `busy`, `done`, `div0` = 0; `quotient`, `remainder` = 0; counter = 0. Reset overrides `cancel` and `start`.

## Timing
- Cycle 0 (IDLE): `start` sampled high.
- Cycles 1–32: CALC, `busy` = 1.
- Cycle 33: FIX, `busy` = 1.
- Cycle 34: DONE, `busy` = 1, `done` = 1, results valid.
- Cycle 35: IDLE, `busy` = 0. The earliest next accepted start is cycle 35.
- Divide-by-zero: start at cycle 0, DONE at cycle 1, IDLE at cycle 2.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `div_pkg`:
  - state enum (IDLE, CALC, FIX, DONE);
  - `DIV_WIDTH` = 32;
  - `DIV_ITER` = 32;
  - the div-by-zero quotient constant 32'hFFFFFFFF.
- Sub-module `div_step` (combinational): one shift-subtract step. Inputs are the partial remainder, the partial quotient and the divisor; outputs are the next remainder and the next quotient.
- The FSM, counter, sign latches and FIX negation live in `div_unit`.

## Test plan
- Unsigned: `Sign`=0, 100 / 7, start at cycle 0 → quotient 14, remainder 2, `done` at cycle 34 only, `busy` high for cycles 1–34.
- Signed: `Sign`=1, 0xFFFFFFF9 (−7) / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- Overflow: `Sign`=1, 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, `div0` = 0. Same operands with `Sign`=0 → quotient 0, remainder 0x80000000.
- Divide-by-zero: 1234 / 0 → `done` at cycle 1, `div0` = 1, quotient 0xFFFFFFFF, remainder 1234; the next normal divide clears `div0`.
- Protocol: start 100/7; assert `start` with other operands at cycle 10 → ignored, result still 14 r 2. Repeat with `cancel` at cycle 10 → `busy` low at cycle 11, no `done`, old results held.
- Reset: drive `reset` low at cycle 20 of a divide → next cycle all outputs 0 and state IDLE. A start issued after reset completes normally.
